cfu_cmd_sequencer: RTL and testbench
====================================

// Module: cfu_cmd_sequencer
// PURPOSE
//  Sequences CPU custom-instruction commands onto the conv1d SIMD datapath.
//  Accepts CFU cmd handshakes, latches operands, drives the datapath, waits
//  for its output-valid, then holds the result until the CPU takes it.
//  Adds a timeout watchdog and a locally served status/control function.
//  Sits between the CFU bus and the conv1d engine inside the Cfu top.
// PARAMETERS
//  TIMEOUT_CYCLES  256          max WAIT cycles before error response; 0 = no timeout
//  CTRL_FUNCT7     7'h7F        funct7 served locally (never sent to datapath)
//  ERR_WORD        32'hDEADBEEF rsp data returned on timeout
// PORTS
//  clk                      in   1   clock
//  reset                    in   1   synchronous, active-high reset
//  cmd_valid                in   1   CPU command valid
//  cmd_ready                out  1   sequencer can accept a command
//  cmd_payload_function_id  in   10  [9:3]=funct7, [2:0]=funct3 (ignored)
//  cmd_payload_inputs_0     in   32  operand 0
//  cmd_payload_inputs_1     in   32  operand 1
//  rsp_valid                out  1   response valid (registered)
//  rsp_ready                in   1   CPU accepts response
//  rsp_payload_outputs_0    out  32  response data (registered, stable while rsp_valid)
//  dp_en                    out  1   datapath enable pulse
//  dp_cmd                   out  7   funct7 to datapath
//  dp_inp0 / dp_inp1        out  32  latched operands to datapath
//  dp_ret                   in   32  datapath result
//  dp_valid                 in   1   datapath result valid
//  err_sticky               out  1   set on timeout, cleared by CTRL status read
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1; rsp_valid=0; rsp data=0; dp_en=0;
//   dp_cmd/dp_inp*=0; err_sticky=0; timeout counter=0; perf counters=0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; cmd_ready = (state==IDLE).
//  IDLE: on cmd_valid: latch funct7, inputs_0/1. funct7==CTRL_FUNCT7 -> load
//   local result, go RESP (1-cycle latency); else -> ISSUE.
//  ISSUE: dp_en=1 exactly one cycle, dp_cmd/dp_inp* from latches (held stable
//   through WAIT). dp_valid this cycle -> capture dp_ret, RESP; else WAIT.
//  WAIT: dp_en=0; counter++ each cycle. dp_valid -> capture dp_ret, RESP.
//   Counter reaches TIMEOUT_CYCLES (nonzero) w/o dp_valid -> data=ERR_WORD,
//   err_sticky=1, RESP. dp_valid on the expiry cycle wins (real data, no error).
//  RESP: rsp_valid=1, data held. rsp_ready=1 -> rsp_valid=0, IDLE next cycle.
//   rsp_ready high on the first RESP cycle completes that cycle.
//  Min datapath latency: accept @T, dp_en @T+1, rsp_valid @T+2; one command in
//   flight; no overlap of next cmd with pending rsp.
//  dp_valid outside ISSUE/WAIT ignored. Reset in any state aborts the
//   operation immediately; no response is produced for the aborted command.
//  CTRL read (inputs_0[1:0]): 0 -> {31'b0, err_sticky}, then err_sticky cleared
//   (same-cycle new timeout impossible: FSM in IDLE); 1,2 -> perf regs;
//   3 -> clear perf counters, returns 0.
// CONFIGURATION
//  CFU_SEQ_PERF_EN defined: 32-bit cmd_count (incr per datapath command
//   accepted, wraps at 2^32) and busy_cycles (incr every ISSUE/WAIT cycle,
//   wraps); CTRL sel 1 returns cmd_count, sel 2 returns busy_cycles, sel 3 clears.
//  Not defined: counters absent; CTRL sel 1/2/3 return 32'h0; sel 0 unchanged.
// TESTING
//  1) reset, funct7=5, dp_valid in ISSUE w/ dp_ret=0x1234 -> rsp_valid @T+2, data 0x1234, one dp_en pulse.
//  2) dp_valid 10 cycles after dp_en, rsp_ready low 3 cycles -> cmd_ready=0 throughout, data stable, IDLE after accept.
//  3) TIMEOUT_CYCLES=4, no dp_valid -> rsp 0xDEADBEEF, err_sticky=1; CTRL sel0 -> 1, then err_sticky=0.
//  4) reset asserted in WAIT -> next cycle cmd_ready=1, rsp_valid=0, dp_en=0, late dp_valid ignored.
//  5) PERF_EN: 3 datapath cmds, 2 WAIT cycles each -> sel1=3, sel2=9; sel3 -> both 0.
//  6) CTRL_FUNCT7 cmd -> dp_en never asserts, rsp_valid @T+1.

Source files
------------

// File: rtl/cfu_cmd_sequencer.sv
// Sequences CFU custom-instruction commands onto the conv1d datapath, with a timeout watchdog
// and a locally served status/control funct7. Define CFU_SEQ_PERF_EN to build the perf counters.
module cfu_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [6:0]  CTRL_FUNCT7    = 7'h7F,
    parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        dp_en,
    output logic [6:0]  dp_cmd,
    output logic [31:0] dp_inp0,
    output logic [31:0] dp_inp1,
    input  logic [31:0] dp_ret,
    input  logic        dp_valid,
    output logic        err_sticky
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e      state_q;
    logic [31:0] to_cnt_q;
    logic [31:0] rsp_data_q;
    logic        rsp_valid_q;
    logic        dp_en_q;
    logic [6:0]  dp_cmd_q;
    logic [31:0] dp_inp0_q;
    logic [31:0] dp_inp1_q;
    logic        err_q;

    logic        cmd_fire_d;
    logic        is_ctrl_d;
    logic [1:0]  ctrl_sel_d;
    logic        to_expire_d;
    logic [31:0] ctrl_rdata_d;
    logic [31:0] perf_cmd_count;
    logic [31:0] perf_busy_cycles;
    logic        unused_funct3;

    assign unused_funct3 = ^cmd_payload_function_id[2:0];
    assign cmd_fire_d    = cmd_valid && (state_q == S_IDLE);
    assign is_ctrl_d     = (cmd_payload_function_id[9:3] == CTRL_FUNCT7);
    assign ctrl_sel_d    = cmd_payload_inputs_0[1:0];
    // Fires on the WAIT cycle whose count reaches the limit; a zero limit disables it.
    assign to_expire_d   = (TIMEOUT_CYCLES != 0) && ((to_cnt_q + 32'd1) == TIMEOUT_CYCLES);

`ifdef CFU_SEQ_PERF_EN
    logic [31:0] cmd_count_q;
    logic [31:0] busy_cycles_q;
    logic        perf_clr_d;
    logic        dp_fire_d;
    logic        busy_d;

    assign perf_clr_d = cmd_fire_d && is_ctrl_d && (ctrl_sel_d == 2'd3);
    assign dp_fire_d  = cmd_fire_d && !is_ctrl_d;
    assign busy_d     = (state_q == S_ISSUE) || (state_q == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset || perf_clr_d) begin
            cmd_count_q   <= 32'h0;
            busy_cycles_q <= 32'h0;
        end else begin
            if (dp_fire_d) cmd_count_q <= cmd_count_q + 32'd1;
            if (busy_d)    busy_cycles_q <= busy_cycles_q + 32'd1;
        end
    end

    assign perf_cmd_count   = cmd_count_q;
    assign perf_busy_cycles = busy_cycles_q;
`else
    assign perf_cmd_count   = 32'h0;
    assign perf_busy_cycles = 32'h0;
`endif

    always_comb begin
        ctrl_rdata_d = 32'h0;
        case (ctrl_sel_d)
            2'd0:    ctrl_rdata_d = {31'b0, err_q};
            2'd1:    ctrl_rdata_d = perf_cmd_count;
            2'd2:    ctrl_rdata_d = perf_busy_cycles;
            default: ctrl_rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            to_cnt_q    <= 32'h0;
            rsp_data_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            dp_en_q     <= 1'b0;
            dp_cmd_q    <= 7'h0;
            dp_inp0_q   <= 32'h0;
            dp_inp1_q   <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (is_ctrl_d) begin
                            rsp_data_q  <= ctrl_rdata_d;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                            if (ctrl_sel_d == 2'd0) err_q <= 1'b0;
                        end else begin
                            dp_cmd_q  <= cmd_payload_function_id[9:3];
                            dp_inp0_q <= cmd_payload_inputs_0;
                            dp_inp1_q <= cmd_payload_inputs_1;
                            dp_en_q   <= 1'b1;
                            to_cnt_q  <= 32'h0;
                            state_q   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    dp_en_q <= 1'b0;
                    if (dp_valid) begin
                        rsp_data_q  <= dp_ret;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    to_cnt_q <= to_cnt_q + 32'd1;
                    // Real data beats the watchdog when both land on the same cycle.
                    if (dp_valid) begin
                        rsp_data_q  <= dp_ret;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (to_expire_d) begin
                        rsp_data_q  <= ERR_WORD;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready             = (state_q == S_IDLE);
    assign rsp_valid             = rsp_valid_q;
    assign rsp_payload_outputs_0 = rsp_data_q;
    assign dp_en                 = dp_en_q;
    assign dp_cmd                = dp_cmd_q;
    assign dp_inp0               = dp_inp0_q;
    assign dp_inp1               = dp_inp1_q;
    assign err_sticky            = err_q;

endmodule

// File: tb/tb_cfu_cmd_sequencer.sv
// Scoreboard bench for cfu_cmd_sequencer: expected responses queued at issue, checked on handshake.
module tb_cfu_cmd_sequencer;
    localparam int          TO      = 12;
    localparam logic [6:0]  CTRL_F7 = 7'h7F;
    localparam logic [31:0] ERR     = 32'hDEADBEEF;
`ifdef CFU_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        dp_en;
    logic [6:0]  dp_cmd;
    logic [31:0] dp_inp0;
    logic [31:0] dp_inp1;
    logic [31:0] dp_ret;
    logic        dp_valid;
    logic        err_sticky;

    int          checks    = 0;
    int          failures  = 0;
    int          dp_en_cnt = 0;
    int          rsp_cnt   = 0;
    logic [31:0] exp_q[$];

    cfu_cmd_sequencer #(.TIMEOUT_CYCLES(TO), .CTRL_FUNCT7(CTRL_F7), .ERR_WORD(ERR)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_data),
        .dp_en                   (dp_en),
        .dp_cmd                  (dp_cmd),
        .dp_inp0                 (dp_inp0),
        .dp_inp1                 (dp_inp1),
        .dp_ret                  (dp_ret),
        .dp_valid                (dp_valid),
        .err_sticky              (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs change just after posedge, so a negedge sample sees what the next edge will see.
    always @(negedge clk) begin
        if (dp_en) dp_en_cnt++;
        if (rsp_valid && rsp_ready && !reset) begin
            logic [31:0] e;
            check_eq("sb_pending", {31'b0, exp_q.size() > 0}, 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
            check_eq("rsp_data", rsp_data, e);
            rsp_cnt++;
            $display("rsp #%0d data=%h exp=%h", rsp_cnt, rsp_data, e);
        end
    end

    // dly: cycles after the dp_en cycle before dp_valid (0 = during ISSUE, <0 = never).
    task automatic dp_cmd_run(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] ret, input int dly, input int rdy_wait);
        logic [31:0] exp;
        int n;
        int en0;
        exp = (dly < 0) ? ERR : ret;
        check_eq("cmd_ready_idle", cmd_ready, 32'd1);
        en0 = dp_en_cnt;
        cmd_valid = 1'b1; fid = {f7, 3'b011}; in0 = a; in1 = b;
        exp_q.push_back(exp);
        step();
        cmd_valid = 1'b0; fid = 10'h0; in0 = 32'h0; in1 = 32'h0;
        check_eq("dp_en_issue", dp_en, 32'd1);
        check_eq("dp_cmd", dp_cmd, f7);
        check_eq("dp_inp0", dp_inp0, a);
        check_eq("dp_inp1", dp_inp1, b);
        check_eq("cmd_ready_busy", cmd_ready, 32'd0);
        n = 0;
        while (!rsp_valid && n < 400) begin
            dp_valid = (n == dly);
            dp_ret   = (n == dly) ? ret : ~ret;
            step();
            n++;
            if (!rsp_valid) begin
                check_eq("dp_en_wait", dp_en, 32'd0);
                check_eq("dp_inp0_hold", dp_inp0, a);
                check_eq("cmd_ready_wait", cmd_ready, 32'd0);
            end
        end
        dp_valid = 1'b0;
        check_eq("rsp_latency", n, (dly < 0) ? TO + 1 : dly + 1);
        check_eq("err_sticky", err_sticky, {31'b0, dly < 0});
        for (int i = 0; i < rdy_wait; i++) begin
            check_eq("rsp_hold_valid", rsp_valid, 32'd1);
            check_eq("rsp_hold_data", rsp_data, exp);
            check_eq("cmd_ready_resp", cmd_ready, 32'd0);
            dp_valid = 1'b1;
            dp_ret   = 32'hBAD00000 + i;
            step();
        end
        dp_valid = 1'b0;
        check_eq("rsp_final_data", rsp_data, exp);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("rsp_valid_drop", rsp_valid, 32'd0);
        check_eq("cmd_ready_back", cmd_ready, 32'd1);
        check_eq("dp_en_pulses", dp_en_cnt - en0, 32'd1);
    endtask

    task automatic ctrl_run(input logic [1:0] sel, input logic [31:0] exp);
        int en0;
        en0 = dp_en_cnt;
        check_eq("ctrl_cmd_ready", cmd_ready, 32'd1);
        cmd_valid = 1'b1;
        fid = {CTRL_F7, 3'b110};
        in0 = ($urandom() & 32'hFFFFFFFC) | {30'b0, sel};
        in1 = $urandom();
        exp_q.push_back(exp);
        step();
        cmd_valid = 1'b0;
        check_eq("ctrl_latency", rsp_valid, 32'd1);
        check_eq("ctrl_no_dp_en", dp_en, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("ctrl_rsp_drop", rsp_valid, 32'd0);
        check_eq("ctrl_dp_pulses", dp_en_cnt - en0, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; fid = 10'h0; in0 = 32'h0; in1 = 32'h0;
        rsp_ready = 1'b0; dp_ret = 32'h0; dp_valid = 1'b0;
        repeat (3) step();
        check_eq("rst_cmd_ready", cmd_ready, 32'd1);
        check_eq("rst_rsp_valid", rsp_valid, 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_dp_en", dp_en, 32'd0);
        check_eq("rst_dp_cmd", dp_cmd, 32'd0);
        check_eq("rst_dp_inp0", dp_inp0, 32'd0);
        check_eq("rst_dp_inp1", dp_inp1, 32'd0);
        check_eq("rst_err", err_sticky, 32'd0);
        reset = 1'b0;
        step();

        dp_cmd_run(7'd5, 32'h11111111, 32'h22222222, 32'h00001234, 0, 0);
        dp_cmd_run(7'h11, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hCAFEF00D, 10, 3);
        dp_cmd_run(7'h12, 32'h01020304, 32'h05060708, 32'h0BADC0DE, TO, 1);
        for (int k = 0; k < 4; k++)
            dp_cmd_run(7'($urandom_range(0, 126)), $urandom(), $urandom(), $urandom(),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));

        dp_cmd_run(7'h20, 32'h0, 32'h0, 32'h0, -1, 2);
        ctrl_run(2'd0, 32'd1);
        check_eq("err_cleared", err_sticky, 32'd0);
        ctrl_run(2'd0, 32'd0);

        cmd_valid = 1'b1; fid = {7'h22, 3'b0}; in0 = 32'h1; in1 = 32'h2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("abort_cmd_ready", cmd_ready, 32'd1);
        check_eq("abort_rsp_valid", rsp_valid, 32'd0);
        check_eq("abort_dp_en", dp_en, 32'd0);
        check_eq("abort_dp_cmd", dp_cmd, 32'd0);
        dp_valid = 1'b1; dp_ret = 32'h0000FACE;
        step();
        dp_valid = 1'b0;
        check_eq("late_dp_rsp_valid", rsp_valid, 32'd0);
        check_eq("late_dp_cmd_ready", cmd_ready, 32'd1);

        for (int k = 0; k < 3; k++)
            dp_cmd_run(7'h30 + 7'(k), $urandom(), $urandom(), 32'h100 + k, 2, 0);
        ctrl_run(2'd1, PERF ? 32'd3 : 32'd0);
        ctrl_run(2'd2, PERF ? 32'd9 : 32'd0);
        ctrl_run(2'd3, 32'd0);
        ctrl_run(2'd1, 32'd0);
        ctrl_run(2'd2, 32'd0);

        step();
        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
